cpu_ctrl_mem: RTL and testbench

- Parametrised multi-cycle controller for the simple RISC datapath. Contains the instruction register, instruction decoder, program counter, data-address register and control FSM.
- Adds instruction fetch from memory and LDR/STR over a ready-handshake memory port. Also adds HALT, a memory-wait timeout and an illegal-opcode error.
- Sits between the memory/IO fabric and the existing datapath (register file, shifter, ALU, status register).

---
 rtl/cpu_ctrl_mem_if.sv | 13 +
 rtl/cpu_ctrl_mem.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_ctrl_mem.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_mem_if.sv
// Memory/IO port of the CPU controller: command, address and ready-handshake read data.
interface cpu_ctrl_mem_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
);
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (output mem_cmd, output mem_addr, input mem_rdata, input mem_ready);
  modport slave  (input mem_cmd, input mem_addr, output mem_rdata, output mem_ready);
endinterface

// File: rtl/cpu_ctrl_mem.sv
// Multi-cycle RISC controller: IR, decoder, PC, data-address register and control FSM
// with instruction fetch, LDR/STR over a ready handshake, HALT, wait timeout and illegal-opcode error.
module cpu_ctrl_mem #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned PC_RESET    = 0,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_ctrl_mem_if.master       mem,
  input  logic [DATA_W-1:0]    datapath_out_i,
  output logic [DATA_W-1:0]    mdata_o,
  output logic                 loada_o,
  output logic                 loadb_o,
  output logic                 loadc_o,
  output logic                 loads_o,
  output logic                 asel_o,
  output logic                 bsel_o,
  output logic                 write_o,
  output logic [1:0]           vsel_o,
  output logic [2:0]           readnum_o,
  output logic [2:0]           writenum_o,
  output logic [1:0]           shift_o,
  output logic [1:0]           alu_op_o,
  output logic [DATA_W-1:0]    sximm5_o,
  output logic [DATA_W-1:0]    sximm8_o,
  output logic [ADDR_W-1:0]    pc_o,
  output logic                 halted_o,
  output logic                 err_o
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [1:0]  CMD_NONE  = 2'b00;
  localparam logic [1:0]  CMD_READ  = 2'b01;
  localparam logic [1:0]  CMD_WRITE = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF, S_UPD, S_DEC, S_GETA, S_GETB, S_EXEC, S_CMP, S_WREG,
    S_WIMM, S_ADDR, S_LADR, S_SGETB, S_SEXE, S_MRD, S_MWR, S_HALT
  } state_t;

  typedef enum logic [2:0] {C_MOVI, C_MOVS, C_ALU, C_LDR, C_STR, C_HALT, C_ILL} cls_t;

  typedef struct packed {
    logic       loada, loadb, loadc, loads, asel, bsel, write, halted;
    logic [1:0] vsel, mem_cmd, shift, alu_op;
    logic [2:0] readnum, writenum;
  } ctl_t;

  function automatic cls_t classify(input logic [15:0] ir);
    cls_t c;
    casez (ir[15:11])
      5'b110_10: c = C_MOVI;
      5'b110_00: c = C_MOVS;
      5'b101_??: c = C_ALU;
      5'b011_00: c = C_LDR;
      5'b100_00: c = C_STR;
      5'b111_00: c = C_HALT;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  // Control word for the state about to be entered; registered so outputs come straight from flops.
  function automatic ctl_t decode(input state_t s, input logic [15:0] ir);
    ctl_t c;
    c        = '0;
    c.shift  = ir[4:3];
    c.alu_op = ir[12:11];
    case (s)
      S_IF:    c.mem_cmd = CMD_READ;
      S_GETA:  begin c.readnum = ir[10:8]; c.loada = 1'b1; end
      S_GETB:  begin c.readnum = ir[2:0];  c.loadb = 1'b1; end
      S_EXEC:  begin c.loadc = 1'b1; c.asel = (classify(ir) == C_MOVS); end
      S_CMP:   c.loads = 1'b1;
      S_WREG:  begin c.write = 1'b1; c.writenum = ir[7:5]; end
      S_WIMM:  begin c.write = 1'b1; c.writenum = ir[10:8]; c.vsel = 2'b10; end
      S_ADDR:  begin c.bsel = 1'b1; c.loadc = 1'b1; c.alu_op = 2'b00; end
      S_SGETB: begin c.readnum = ir[7:5]; c.loadb = 1'b1; c.shift = 2'b00; end
      S_SEXE:  begin c.asel = 1'b1; c.loadc = 1'b1; c.shift = 2'b00; end
      S_MRD:   c.mem_cmd = CMD_READ;
      S_MWR:   c.mem_cmd = CMD_WRITE;
      S_HALT:  c.halted = 1'b1;
      default: c = c;
    endcase
    return c;
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d, daddr_q, daddr_d, mem_addr_q;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              err_q, err_d;
  ctl_t              ctl_q, ctl_d;
  cls_t              cls_c;
  logic              mem_wait_c, addr_sel_c, mrd_done_c;
  logic              unused_ok;

  assign cls_c     = classify(ir_q);
  assign unused_ok = ^datapath_out_i[DATA_W-1:ADDR_W];

  // Next-state, PC/IR/data-address updates and wait-cycle timeout.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    daddr_d    = daddr_q;
    wait_d     = '0;
    err_d      = err_q;
    mem_wait_c = 1'b0;
    case (state_q)
      S_RST:   state_d = S_IF;
      S_IF: begin
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata[15:0];
          state_d = S_UPD;
        end else begin
          mem_wait_c = 1'b1;
        end
      end
      S_UPD: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DEC;
      end
      S_DEC: begin
        case (cls_c)
          C_MOVI:       state_d = S_WIMM;
          C_MOVS:       state_d = S_GETB;
          C_ALU:        state_d = (ir_q[12:11] == 2'b11) ? S_GETB : S_GETA;
          C_LDR, C_STR: state_d = S_GETA;
          C_HALT:       state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
        endcase
      end
      S_GETA:  state_d = (cls_c == C_ALU) ? S_GETB : S_ADDR;
      S_GETB:  state_d = (cls_c == C_ALU && ir_q[12:11] == 2'b01) ? S_CMP : S_EXEC;
      S_EXEC:  state_d = S_WREG;
      S_CMP, S_WREG, S_WIMM: state_d = S_IF;
      S_ADDR:  state_d = S_LADR;
      S_LADR: begin
        daddr_d = datapath_out_i[ADDR_W-1:0];
        state_d = (cls_c == C_LDR) ? S_MRD : S_SGETB;
      end
      S_SGETB: state_d = S_SEXE;
      S_SEXE:  state_d = S_MWR;
      S_MRD, S_MWR: begin
        if (mem.mem_ready) state_d = S_IF;
        else               mem_wait_c = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    if (mem_wait_c && MEM_TIMEOUT != 0) begin
      if (wait_q == CNT_W'(MEM_TIMEOUT - 1)) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + CNT_W'(1);
      end
    end
  end

  assign ctl_d      = decode(state_d, ir_d);
  assign addr_sel_c = (state_d == S_MRD) || (state_d == S_MWR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_RST;
      ir_q       <= '0;
      pc_q       <= ADDR_W'(PC_RESET);
      daddr_q    <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      ctl_q      <= '0;
      mem_addr_q <= ADDR_W'(PC_RESET);
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      daddr_q    <= daddr_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      ctl_q      <= ctl_d;
      mem_addr_q <= addr_sel_c ? daddr_d : pc_d;
    end
  end

  // Load writeback happens in the same cycle the memory returns data.
  assign mrd_done_c = (state_q == S_MRD) && mem.mem_ready;

  assign mem.mem_cmd  = ctl_q.mem_cmd;
  assign mem.mem_addr = mem_addr_q;
  assign mdata_o      = mem.mem_rdata;
  assign loada_o      = ctl_q.loada;
  assign loadb_o      = ctl_q.loadb;
  assign loadc_o      = ctl_q.loadc;
  assign loads_o      = ctl_q.loads;
  assign asel_o       = ctl_q.asel;
  assign bsel_o       = ctl_q.bsel;
  assign write_o      = ctl_q.write | mrd_done_c;
  assign vsel_o       = mrd_done_c ? 2'b11 : ctl_q.vsel;
  assign readnum_o    = ctl_q.readnum;
  assign writenum_o   = mrd_done_c ? ir_q[7:5] : ctl_q.writenum;
  assign shift_o      = ctl_q.shift;
  assign alu_op_o     = ctl_q.alu_op;
  assign sximm5_o     = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
  assign sximm8_o     = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign pc_o         = pc_q;
  assign halted_o     = ctl_q.halted;
  assign err_o        = err_q;

endmodule

// File: tb/tb_cpu_ctrl_mem.sv
// Randomised bench for cpu_ctrl_mem: per-instruction expected control sequences derived
// from the instruction class, a random-latency memory responder and timeout/reset scenarios.
module tb_cpu_ctrl_mem;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 6;
  localparam int unsigned PCR = 3;
  localparam int unsigned TO  = 4;

  localparam int K_MOVI = 0, K_MOVS = 1, K_ALU = 2, K_LDR = 3, K_STR = 4, K_HALT = 5, K_ILL = 6;

  typedef struct packed {
    logic la, lb, lc, ls, as, bs, wr;
    logic [1:0] vsel;
    logic [2:0] rn, wn;
    logic [1:0] sh, aop, cmd;
    logic [AW-1:0] addr;
    logic hl, er;
    logic [AW-1:0] pc;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata, dp, mdata, sximm5, sximm8;
  logic          loada, loadb, loadc, loads, asel, bsel, write, halted, err;
  logic [1:0]    vsel, shift, alu_op;
  logic [2:0]    readnum, writenum;
  logic [AW-1:0] pc;

  cpu_ctrl_mem_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();
  assign mif.mem_ready = mem_ready;
  assign mif.mem_rdata = mem_rdata;

  cpu_ctrl_mem #(.DATA_W(DW), .ADDR_W(AW), .PC_RESET(PCR), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem(mif), .datapath_out_i(dp), .mdata_o(mdata),
    .loada_o(loada), .loadb_o(loadb), .loadc_o(loadc), .loads_o(loads),
    .asel_o(asel), .bsel_o(bsel), .write_o(write), .vsel_o(vsel),
    .readnum_o(readnum), .writenum_o(writenum), .shift_o(shift), .alu_op_o(alu_op),
    .sximm5_o(sximm5), .sximm8_o(sximm8), .pc_o(pc), .halted_o(halted), .err_o(err)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [AW-1:0] pc_m;
  logic [15:0]   ir_m;
  logic          err_m;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h pc_m=%0d t=%0t", tag, got, exp, pc_m, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.la = loada; o.lb = loadb; o.lc = loadc; o.ls = loads; o.as = asel; o.bs = bsel;
    o.wr = write; o.vsel = vsel; o.rn = readnum; o.wn = writenum; o.sh = shift;
    o.aop = alu_op; o.cmd = mif.mem_cmd; o.addr = mif.mem_addr; o.hl = halted;
    o.er = err; o.pc = pc;
    return o;
  endfunction

  // Idle expectation: no controls, PC on the address bus, IR-derived shift/ALUop.
  function automatic obs_t base();
    obs_t e = '0;
    e.sh = ir_m[4:3]; e.aop = ir_m[12:11];
    e.addr = pc_m; e.pc = pc_m; e.er = err_m;
    return e;
  endfunction

  function automatic int kind(input logic [15:0] ir);
    int k;
    casez (ir[15:11])
      5'b110_10: k = K_MOVI;
      5'b110_00: k = K_MOVS;
      5'b101_??: k = K_ALU;
      5'b011_00: k = K_LDR;
      5'b100_00: k = K_STR;
      5'b111_00: k = K_HALT;
      default:   k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic logic [15:0] rand_legal();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(0, 4))
      0:       r[15:11] = 5'b110_10;
      1:       r[15:11] = 5'b110_00;
      2:       r[15:13] = 3'b101;
      3:       r[15:11] = 5'b011_00;
      default: r[15:11] = 5'b100_00;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] rand_stop();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       r[15:11] = 5'b111_00;
      1:       r[15:13] = 3'($urandom_range(0, 2));
      2:       r[15:11] = 5'b110_01;
      default: r[15:11] = 5'b011_01;
    endcase
    return r;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
  endfunction

  task automatic drive(input logic rdy, input logic [DW-1:0] rd);
    mem_ready = rdy;
    mem_rdata = rd;
    dp        = DW'($urandom);
  endtask

  task automatic drive_idle();
    drive(1'($urandom_range(0, 1)), DW'($urandom));
  endtask

  task automatic cyc(input string tag, input obs_t e);
    #1;
    check_eq(tag, 64'(sample()), 64'(e));
    @(negedge clk);
  endtask

  // One memory access: waits idle cycles, then ready; a timeout or reset request ends it early.
  task automatic mem_phase(input string tag, input logic [1:0] cmd, input logic [AW-1:0] addr,
                           input int waits, input logic [DW-1:0] rd, input bit is_rd,
                           input int rst_at, output bit to, output bit ab);
    obs_t e;
    to = 1'b0;
    ab = 1'b0;
    for (int w = 0; w <= int'(TO); w++) begin
      if (w == int'(TO)) begin
        to = 1'b1;
        return;
      end
      if (w == rst_at) begin
        ab = 1'b1;
        return;
      end
      e = base(); e.cmd = cmd; e.addr = addr;
      if (w == waits) begin
        drive(1'b1, rd);
        if (is_rd) begin e.wr = 1'b1; e.wn = ir_m[7:5]; e.vsel = 2'b11; end
        cyc(tag, e);
        if (is_rd) check_eq("MDATA", 64'(mdata), 64'(rd));
        return;
      end
      drive(1'b0, DW'($urandom));
      cyc({tag, "_WAIT"}, e);
    end
  endtask

  task automatic halt_check();
    obs_t e;
    repeat (2) begin
      drive_idle(); e = base(); e.hl = 1'b1; cyc("HALT", e);
    end
  endtask

  task automatic do_reset();
    obs_t e;
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
    pc_m = AW'(PCR); err_m = 1'b0; ir_m = '0;
    e = base();
    cyc("RST", e);
  endtask

  task automatic run_instr(input logic [15:0] ir, input int wif, input int wmem,
                           input int rst_at, output bit stop);
    obs_t e;
    bit to, ab, rd_op;
    int k;
    logic [AW-1:0] daddr;
    logic [DW-1:0] rd;
    stop = 1'b1;
    mem_phase("IF", 2'b01, pc_m, wif, DW'(ir), 1'b0, -1, to, ab);
    if (to) begin err_m = 1'b1; halt_check(); return; end
    ir_m = ir;
    drive_idle(); e = base(); cyc("UPD", e);
    check_eq("SXIMM5", 64'(sximm5), 64'({{11{ir[4]}}, ir[4:0]}));
    check_eq("SXIMM8", 64'(sximm8), 64'({{8{ir[7]}}, ir[7:0]}));
    pc_m = AW'(pc_m + 1);
    drive_idle(); e = base(); cyc("DEC", e);
    k = kind(ir);
    if (k == K_HALT || k == K_ILL) begin
      if (k == K_ILL) err_m = 1'b1;
      halt_check();
      return;
    end
    stop = 1'b0;
    if (k == K_MOVI) begin
      drive_idle(); e = base(); e.wr = 1'b1; e.wn = ir[10:8]; e.vsel = 2'b10; cyc("WIMM", e);
      return;
    end
    if (!(k == K_MOVS || (k == K_ALU && ir[12:11] == 2'b11))) begin
      drive_idle(); e = base(); e.la = 1'b1; e.rn = ir[10:8]; cyc("GETA", e);
    end
    if (k == K_MOVS || k == K_ALU) begin
      drive_idle(); e = base(); e.lb = 1'b1; e.rn = ir[2:0]; cyc("GETB", e);
      drive_idle(); e = base();
      if (k == K_ALU && ir[12:11] == 2'b01) begin
        e.ls = 1'b1; cyc("CMP", e);
      end else begin
        e.lc = 1'b1; e.as = (k == K_MOVS); cyc("EXEC", e);
        drive_idle(); e = base(); e.wr = 1'b1; e.wn = ir[7:5]; cyc("WREG", e);
      end
      return;
    end
    drive_idle(); e = base(); e.bs = 1'b1; e.lc = 1'b1; e.aop = 2'b00; cyc("ADDR", e);
    drive_idle(); daddr = dp[AW-1:0]; e = base(); cyc("LADR", e);
    if (k == K_STR) begin
      drive_idle(); e = base(); e.lb = 1'b1; e.rn = ir[7:5]; e.sh = 2'b00; cyc("SGETB", e);
      drive_idle(); e = base(); e.as = 1'b1; e.lc = 1'b1; e.sh = 2'b00; cyc("SEXE", e);
    end
    rd    = DW'($urandom);
    rd_op = (k == K_LDR);
    mem_phase(rd_op ? "MRD" : "MWR", rd_op ? 2'b01 : 2'b10, daddr, wmem, rd, rd_op,
              rst_at, to, ab);
    if (ab) begin
      stop = 1'b1;
    end else if (to) begin
      err_m = 1'b1;
      halt_check();
      stop = 1'b1;
    end
  endtask

  task automatic run(input logic [15:0] ir, input int wif, input int wmem, input int rst_at);
    bit stop;
    run_instr(ir, wif, wmem, rst_at, stop);
    if (stop) do_reset();
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b0; mem_rdata = '0; dp = '0;
    pc_m = AW'(PCR); ir_m = '0; err_m = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    // Directed: MOV imm, ADD, LDR with waits, STR, CMP/AND/MVN/MOV shift.
    run(16'hD105, 0, 0, -1);
    run(16'hA040, 0, 0, -1);
    run(16'h6162, 0, 2, -1);
    run(16'h8162, 1, 1, -1);
    run(16'hA941, 2, 0, -1);
    run(16'hB2A3, 0, 0, -1);
    run(16'hB8E1, 0, 0, -1);
    run(16'hC0FA, 3, 0, -1);
    // Completion on the last allowed cycle, then timeouts in IF and MRD.
    run(16'h6162, 3, 3, -1);
    run(16'hD105, 4, 0, -1);
    run(16'h6162, 0, 4, -1);
    run(16'h8162, 0, 5, -1);
    // HALT, illegal opcode, and reset during an MRD wait.
    run(16'hE000, 0, 0, -1);
    run(16'h0000, 0, 0, -1);
    run(16'h6162, 0, 3, 2);
    // Long legal stream so the PC wraps.
    for (int i = 0; i < 80; i++) run(rand_legal(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
    // Mixed stream with halts, errors, timeouts and occasional mid-access resets.
    for (int i = 0; i < 300; i++) begin
      run(($urandom_range(0, 19) == 0) ? rand_stop() : rand_legal(), rand_wait(), rand_wait(),
          ($urandom_range(0, 29) == 0) ? 1 : -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
